// File: rtl/warships_pkg.sv
// Shared types and defaults for the warships game controller.
package warships_pkg;

    localparam int unsigned SHIP_CELLS_DFLT = 10;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_MISS  = 2'b10,
        CELL_HIT   = 2'b11
    } cell_e;

    typedef enum logic [3:0] {
        ST_CLEAR       = 4'd0,
        ST_IDLE        = 4'd1,
        ST_PLACE_RD    = 4'd2,
        ST_PLACE_CHK   = 4'd3,
        ST_WAIT_ENEMY  = 4'd4,
        ST_DEF_RD      = 4'd5,
        ST_DEF_CHK     = 4'd6,
        ST_DEF_ACK     = 4'd7,
        ST_WAIT_SHOT   = 4'd8,
        ST_SHOT        = 4'd9,
        ST_WAIT_ANSWER = 4'd10,
        ST_SAVE_RESULT = 4'd11,
        ST_WIN         = 4'd12,
        ST_LOSE        = 4'd13,
        ST_LINK_ERR    = 4'd14
    } state_e;

    // Cell code recorded on the enemy board for a peer answer.
    function automatic logic [1:0] shot_result(input logic hit);
        return hit ? CELL_HIT : CELL_MISS;
    endfunction

endpackage

// File: rtl/link_timer.sv
// Counts cycles spent waiting on the peer; expired flags the last allowed cycle.
module link_timer #(
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] cnt;

    // Cycle counter, held at zero whenever not waiting, stops at the last cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYC != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Warships game controller: board clear, ship placement, shot/defence exchange with a peer.
module game_ctrl_fsm
    import warships_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SHIP_CELLS  = SHIP_CELLS_DFLT,
    parameter int unsigned TIMEOUT_CYC = 0,
    localparam int unsigned CTR_W      = $clog2(SHIP_CELLS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_btn,
    output logic              start_btn_en,
    input  logic [ADDR_W-1:0] my_grid_cords,
    input  logic [ADDR_W-1:0] en_grid_cords,
    output logic [ADDR_W-1:0] my_mem_addr,
    output logic [1:0]        my_mem_wdata,
    output logic              my_mem_we,
    input  logic [1:0]        my_mem_rdata,
    output logic [ADDR_W-1:0] en_mem_addr,
    output logic [1:0]        en_mem_wdata,
    output logic              en_mem_we,
    input  logic              ready_in,
    input  logic              hit_in,
    input  logic [ADDR_W-1:0] cords_in,
    output logic              ready_out,
    output logic              hit_out,
    output logic [ADDR_W-1:0] cords_out,
    output logic [CTR_W-1:0]  my_ctr,
    output logic [CTR_W-1:0]  en_ctr,
    output logic [3:0]        state_out,
    output logic              link_err
);

    localparam logic [ADDR_W-1:0] NONE      = '1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = NONE - ADDR_W'(1);
    localparam logic [CTR_W-1:0]  CELLS     = CTR_W'(SHIP_CELLS);

    state_e            state, nxt_state;
    logic [ADDR_W-1:0] clr_addr, nxt_clr_addr;
    logic              nxt_btn_en, nxt_ready, nxt_hit, nxt_link_err;
    logic [ADDR_W-1:0] nxt_my_addr, nxt_en_addr, nxt_cords;
    logic [1:0]        nxt_my_wdata, nxt_en_wdata;
    logic              nxt_my_we, nxt_en_we;
    logic [CTR_W-1:0]  nxt_my_ctr, nxt_en_ctr;
    logic              timer_run, timer_expired;

    assign timer_run = (state == ST_WAIT_ANSWER) || (state == ST_DEF_ACK);
    assign state_out = state;

    link_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_link_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!timer_run),
        .enable  (timer_run),
        .expired (timer_expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_CLEAR;
            clr_addr     <= '0;
            start_btn_en <= 1'b1;
            my_mem_addr  <= '0;
            my_mem_wdata <= '0;
            my_mem_we    <= 1'b0;
            en_mem_addr  <= '0;
            en_mem_wdata <= '0;
            en_mem_we    <= 1'b0;
            ready_out    <= 1'b0;
            hit_out      <= 1'b0;
            cords_out    <= '0;
            my_ctr       <= CELLS;
            en_ctr       <= CELLS;
            link_err     <= 1'b0;
        end else begin
            state        <= nxt_state;
            clr_addr     <= nxt_clr_addr;
            start_btn_en <= nxt_btn_en;
            my_mem_addr  <= nxt_my_addr;
            my_mem_wdata <= nxt_my_wdata;
            my_mem_we    <= nxt_my_we;
            en_mem_addr  <= nxt_en_addr;
            en_mem_wdata <= nxt_en_wdata;
            en_mem_we    <= nxt_en_we;
            ready_out    <= nxt_ready;
            hit_out      <= nxt_hit;
            cords_out    <= nxt_cords;
            my_ctr       <= nxt_my_ctr;
            en_ctr       <= nxt_en_ctr;
            link_err     <= nxt_link_err;
        end
    end

    // Next state and next output values; write enables are single-cycle pulses.
    always_comb begin
        nxt_state    = state;
        nxt_clr_addr = clr_addr;
        nxt_btn_en   = start_btn_en;
        nxt_my_addr  = my_mem_addr;
        nxt_my_wdata = my_mem_wdata;
        nxt_my_we    = 1'b0;
        nxt_en_addr  = en_mem_addr;
        nxt_en_wdata = en_mem_wdata;
        nxt_en_we    = 1'b0;
        nxt_ready    = ready_out;
        nxt_hit      = hit_out;
        nxt_cords    = cords_out;
        nxt_my_ctr   = my_ctr;
        nxt_en_ctr   = en_ctr;
        nxt_link_err = link_err;

        case (state)
            ST_CLEAR: begin
                nxt_my_addr  = clr_addr;
                nxt_my_wdata = CELL_EMPTY;
                nxt_my_we    = 1'b1;
                nxt_en_addr  = clr_addr;
                nxt_en_wdata = CELL_EMPTY;
                nxt_en_we    = 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    nxt_clr_addr = '0;
                    nxt_state    = ST_IDLE;
                end else begin
                    nxt_clr_addr = clr_addr + ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                if (my_ctr == '0) begin
                    if (start_btn) begin
                        nxt_my_ctr = CELLS;
                        nxt_en_ctr = CELLS;
                        nxt_ready  = 1'b1;
                        nxt_hit    = 1'b0;
                        nxt_btn_en = 1'b0;
                        nxt_state  = ready_in ? ST_WAIT_ENEMY : ST_WAIT_SHOT;
                    end
                end else if (my_grid_cords != NONE) begin
                    nxt_my_addr = my_grid_cords;
                    nxt_state   = ST_PLACE_RD;
                end
            end

            ST_PLACE_RD: nxt_state = ST_PLACE_CHK;

            // Only an empty cell takes a ship; duplicates are silently dropped.
            ST_PLACE_CHK: begin
                if ((my_mem_rdata == CELL_EMPTY) && (my_ctr != '0)
                        && (my_mem_addr != NONE)) begin
                    nxt_my_wdata = CELL_SHIP;
                    nxt_my_we    = 1'b1;
                    nxt_my_ctr   = my_ctr - CTR_W'(1);
                end
                nxt_state = ST_IDLE;
            end

            ST_WAIT_ENEMY: begin
                if (ready_in && hit_in) begin
                    nxt_my_addr = cords_in;
                    nxt_ready   = 1'b0;
                    nxt_state   = ST_DEF_RD;
                end
            end

            ST_DEF_RD: nxt_state = ST_DEF_CHK;

            // Re-hitting a HIT cell reports a hit without costing another ship cell.
            ST_DEF_CHK: begin
                nxt_hit = 1'b0;
                if (my_mem_addr != NONE) begin
                    case (my_mem_rdata)
                        CELL_SHIP: begin
                            nxt_my_wdata = CELL_HIT;
                            nxt_my_we    = 1'b1;
                            nxt_hit      = 1'b1;
                            if (my_ctr != '0) begin
                                nxt_my_ctr = my_ctr - CTR_W'(1);
                            end
                        end
                        CELL_HIT: nxt_hit = 1'b1;
                        default: begin
                            nxt_my_wdata = CELL_MISS;
                            nxt_my_we    = 1'b1;
                        end
                    endcase
                end
                nxt_ready = 1'b1;
                nxt_state = ST_DEF_ACK;
            end

            ST_DEF_ACK: begin
                if (ready_in) begin
                    nxt_hit   = 1'b0;
                    nxt_state = (my_ctr == '0) ? ST_LOSE : ST_WAIT_SHOT;
                end else if (timer_expired) begin
                    nxt_link_err = 1'b1;
                    nxt_ready    = 1'b0;
                    nxt_hit      = 1'b0;
                    nxt_state    = ST_LINK_ERR;
                end
            end

            ST_WAIT_SHOT: begin
                if (en_grid_cords != NONE) begin
                    nxt_cords = en_grid_cords;
                    nxt_hit   = 1'b1;
                    nxt_ready = 1'b1;
                    nxt_state = ST_SHOT;
                end
            end

            ST_SHOT: nxt_state = ST_WAIT_ANSWER;

            ST_WAIT_ANSWER: begin
                if (ready_in) begin
                    if (cords_in != NONE) begin
                        nxt_en_addr  = cords_in;
                        nxt_en_wdata = shot_result(hit_in);
                        nxt_en_we    = 1'b1;
                        if (hit_in && (en_ctr != '0)) begin
                            nxt_en_ctr = en_ctr - CTR_W'(1);
                        end
                    end
                    nxt_state = ST_SAVE_RESULT;
                end else if (timer_expired) begin
                    nxt_link_err = 1'b1;
                    nxt_ready    = 1'b0;
                    nxt_hit      = 1'b0;
                    nxt_state    = ST_LINK_ERR;
                end
            end

            ST_SAVE_RESULT: begin
                nxt_hit   = 1'b0;
                nxt_state = (en_ctr == '0) ? ST_WIN : ST_WAIT_ENEMY;
            end

            // Game over: wait for a rematch request, then wipe both boards.
            ST_WIN, ST_LOSE, ST_LINK_ERR: begin
                nxt_btn_en = 1'b1;
                if (start_btn) begin
                    nxt_link_err = 1'b0;
                    nxt_my_ctr   = CELLS;
                    nxt_en_ctr   = CELLS;
                    nxt_ready    = 1'b0;
                    nxt_hit      = 1'b0;
                    nxt_clr_addr = '0;
                    nxt_state    = ST_CLEAR;
                end
            end

            default: nxt_state = ST_CLEAR;
        endcase
    end

endmodule
